de1_soc_sysid_read_arbiter: RTL and testbench
=============================================

// Module: de1_soc_sysid_read_arbiter
// PURPOSE
// - Two-master Avalon-MM read arbiter sharing the single sysid control slave (1-bit address, 32-bit constant readdata).
// - Masters: m0 (Nios/CPU data master) and m1 (boot/JTAG checker).
// - Round-robin grant, one outstanding read, registered response with readdatavalid.
// - Sits between the interconnect and the sysid slave in the de1_soc system.
// PARAMETERS
// - DATA_W       32            readdata width
// - ADDR_W       1             slave address width (0 = system ID, 1 = timestamp)
// - EXPECTED_ID  32'hDEADBEEF  system ID compared by the optional check feature
// PORTS
// - clock             in   1       single system clock, all logic rising-edge
// - reset_n           in   1       asynchronous, active-low reset
// - m0_address        in   ADDR_W  master 0 read address
// - m0_read           in   1       master 0 read request, held until accepted
// - m0_waitrequest    out  1       low for exactly the accept cycle of m0
// - m0_readdata       out  DATA_W  response data, valid when m0_readdatavalid
// - m0_readdatavalid  out  1       one-cycle response strobe for m0
// - m1_*              --   --      identical set for master 1
// - s_address         out  ADDR_W  registered address to sysid slave
// - s_readdata        in   DATA_W  combinational sysid slave data
// - id_mismatch       out  1       sticky ID-check flag (see CONFIGURATION)
// BEHAVIOUR
// - FSM states IDLE -> SAMPLE -> RESP -> IDLE; reset state IDLE.
// - IDLE, no mN_read: stay in IDLE, both waitrequests high.
// - IDLE, any read: winner selected combinationally; winner waitrequest low this cycle (accept).
//   - On the accept edge: s_address <= winner address, owner <= winner, last_grant <= winner, go SAMPLE.
// - SAMPLE: rdata <= s_readdata; go RESP.
// - RESP: owner readdatavalid = 1 and owner readdata = rdata for one cycle; other master readdatavalid = 0; go IDLE.
// - Latency: accept edge to readdatavalid high = 2 cycles; max throughput 1 read per 3 cycles.
// - Both waitrequests are high in SAMPLE and RESP regardless of requests.
// - Arbitration:
//   - Only one requester: it wins.
//   - Both request: the master != last_grant wins.
//   - last_grant resets to 1, so m0 wins the first contended cycle.
// - Loser keeps read asserted with waitrequest high; it is granted in the next IDLE (no starvation, max wait 3 cycles).
// - Read dropped before accept: no transaction, no state change.
// - Read held through RESP by the same master: new accept in the following IDLE. A stale acceptance is never counted twice.
// - Readdata ports are driven from rdata at all times and are meaningful only with readdatavalid.
// - Address bits outside ADDR_W do not exist; address is passed through unmodified (no decode, no error).
// - Reset values:
//   - state IDLE, last_grant 1, owner 0, s_address 0, rdata 0.
//   - readdatavalid 0 on both masters; waitrequest 1 on both masters.
//   - id_mismatch 0.
// - Reset mid-transaction: in-flight read is discarded, no readdatavalid is issued, masters must reissue.
// CONFIGURATION
// - SYSID_ARB_IDCHECK_EN defined:
//   - In RESP with s_address == 0: if rdata != EXPECTED_ID, id_mismatch <= 1.
//   - id_mismatch is sticky until reset_n.
//   - Address-1 (timestamp) reads are never checked.
// - SYSID_ARB_IDCHECK_EN undefined:
//   - id_mismatch tied 0; no compare logic is synthesised.
//   - Arbitration and timing are identical in both builds.
// TESTING
// - m0 reads addr 0 alone, s_readdata = 32'hDEADBEEF:
//   - m0_waitrequest low 1 cycle; m0_readdatavalid 2 cycles later with 32'hDEADBEEF; m1_readdatavalid stays 0.
// - m0 and m1 both read from reset (m0 addr 0, m1 addr 1, slave returns 0xDEADBEEF / 0x5B92B411):
//   - m0 served first with 0xDEADBEEF; then m1 with 0x5B92B411 after its accept in the next IDLE.
// - Both masters hold read continuously for 12 cycles:
//   - Grants alternate m0, m1, m0, m1; exactly 4 readdatavalid pulses; none overlap.
// - m1 asserts read 1 cycle then drops it while waitrequest is high during an m0 transaction:
//   - No m1 transaction; last_grant remains 0.
// - reset_n pulsed low in SAMPLE:
//   - No readdatavalid on either master; all outputs return to reset values asynchronously.
// - IDCHECK build, s_readdata = 32'h12345678, m0 reads addr 0:
//   - id_mismatch rises at the RESP edge and stays 1.
//   - The same stimulus with addr 1 leaves id_mismatch at 0.

Source files
------------

// File: rtl/de1_soc_sysid_read_arbiter.sv
// ---------------------------------------------------------------------------
// de1_soc_sysid_read_arbiter
//
// Two-master Avalon-MM read arbiter in front of the sysid control slave.
// Masters: m0 (CPU data master) and m1 (boot/JTAG checker). Round-robin
// grant, one outstanding read, registered response with a one-cycle
// readdatavalid strobe.
//
// Transaction: IDLE (accept, waitrequest low) -> SAMPLE (capture slave data)
// -> RESP (readdatavalid to owner) -> IDLE. One read per 3 cycles at most.
//
// Ports
//   clock, reset_n        system clock (rising edge), async active-low reset
//   mN_address/mN_read    master N read request, held until accepted
//   mN_waitrequest        low only in master N's accept cycle
//   mN_readdata/valid     registered response; data meaningful with valid
//   s_address             registered address to the sysid slave
//   s_readdata            combinational sysid slave data
//   id_mismatch           sticky ID-check flag
//
// Build option
//   SYSID_ARB_IDCHECK_EN  when defined, a RESP of an address-0 read whose
//                         data differs from EXPECTED_ID sets id_mismatch until
//                         reset. When undefined, id_mismatch is tied low.
// ---------------------------------------------------------------------------
module de1_soc_sysid_read_arbiter #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 1,
  parameter logic [31:0] EXPECTED_ID = 32'hDEADBEEF
) (
  input  logic              clock,
  input  logic              reset_n,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // sysid slave
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata,
  // status
  output logic              id_mismatch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   s_address_q, s_address_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Combinational winner. With both requesting, the master that did not win
  // last time is chosen; last_grant resets to 1 so m0 wins first contention.
  logic gnt0, gnt1, accept;

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    accept = 1'b0;
    if (state_q == IDLE) begin
      gnt0   = m0_read & (~m1_read | last_grant_q);
      gnt1   = m1_read & (~m0_read | ~last_grant_q);
      accept = gnt0 | gnt1;
    end
  end

  // Next-state / datapath
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    s_address_d  = s_address_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = gnt1;
          last_grant_d = gnt1;
          s_address_d  = gnt1 ? m1_address : m0_address;
          state_d      = SAMPLE;
        end
      end
      SAMPLE: begin
        // s_address has been stable for a full cycle; slave data is valid.
        rdata_d = s_readdata;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_address_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      s_address_q  <= s_address_d;
      rdata_q      <= rdata_d;
    end
  end

  // Waitrequest is forced high while reset is asserted so a master holding
  // read through reset never sees a phantom accept.
  assign m0_waitrequest   = ~(reset_n & gnt0);
  assign m1_waitrequest   = ~(reset_n & gnt1);

  assign m0_readdatavalid = (state_q == RESP) & ~owner_q;
  assign m1_readdatavalid = (state_q == RESP) &  owner_q;
  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;
  assign s_address        = s_address_q;

`ifdef SYSID_ARB_IDCHECK_EN
  logic id_mismatch_q;

  // Only system-ID reads (address 0) are checked; timestamp reads are not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_mismatch_q <= 1'b0;
    end else if ((state_q == RESP) && (s_address_q == '0) &&
                 (rdata_q != DATA_W'(EXPECTED_ID))) begin
      id_mismatch_q <= 1'b1;
    end
  end

  assign id_mismatch = id_mismatch_q;
`else
  // Check disabled: flag is constant and the expected ID is only referenced
  // to keep the parameter visibly consumed.
  logic unused_expected_id;
  assign unused_expected_id = ^EXPECTED_ID;
  assign id_mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_de1_soc_sysid_read_arbiter.sv
module tb_de1_soc_sysid_read_arbiter;

  logic        clock;
  logic        reset_n;
  logic [0:0]  m0_address, m1_address;
  logic        m0_read, m1_read;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [0:0]  s_address;
  logic [31:0] s_readdata;
  logic        id_mismatch;
  logic [31:0] id_val;

  int pass_cnt = 0;
  int total    = 0;

  de1_soc_sysid_read_arbiter #(
    .DATA_W(32), .ADDR_W(1), .EXPECTED_ID(32'hDEADBEEF)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_readdata(s_readdata), .id_mismatch(id_mismatch)
  );

  // sysid slave model: address 0 = system ID, address 1 = timestamp
  assign s_readdata = (s_address == 1'b0) ? id_val : 32'h5B92B411;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // inputs change 2ns after a rising edge; outputs sampled 1ns later
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_read = 1'b0; m1_read = 1'b0;
    m0_address = 1'b0; m1_address = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1;
    #1;
    total++; if (m0_waitrequest !== 1'b1) $display("FAIL reset_m0_wait got=%b exp=1", m0_waitrequest); else pass_cnt++;
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL reset_m1_wait got=%b exp=1", m1_waitrequest); else pass_cnt++;
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL reset_rdv got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
    total++; if (s_address !== 1'b0) $display("FAIL reset_saddr got=%b exp=0", s_address); else pass_cnt++;
    total++; if (m0_readdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", m0_readdata); else pass_cnt++;
    total++; if (id_mismatch !== 1'b0) $display("FAIL reset_idm got=%b exp=0", id_mismatch); else pass_cnt++;
  endtask

  task automatic test_single_m0();
    do_reset();
    m0_address = 1'b0; m0_read = 1'b1;
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) $display("FAIL single_accept_wait got=%b exp=01", {m0_waitrequest, m1_waitrequest}); else pass_cnt++;
    tick(); m0_read = 1'b0; #1;   // SAMPLE
    total++; if ({m0_waitrequest, m0_readdatavalid} !== 2'b10) $display("FAIL single_sample got=%b exp=10", {m0_waitrequest, m0_readdatavalid}); else pass_cnt++;
    tick(); #1;                   // RESP
    total++; if (m0_readdatavalid !== 1'b1) $display("FAIL single_rdv got=%b exp=1", m0_readdatavalid); else pass_cnt++;
    total++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL single_data got=%h exp=deadbeef", m0_readdata); else pass_cnt++;
    total++; if (m1_readdatavalid !== 1'b0) $display("FAIL single_m1_rdv got=%b exp=0", m1_readdatavalid); else pass_cnt++;
    tick(); #1;                   // IDLE
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL single_rdv_pulse got=%b exp=0", m0_readdatavalid); else pass_cnt++;
  endtask

  task automatic test_contention();
    do_reset();
    m0_address = 1'b0; m1_address = 1'b1;
    m0_read = 1'b1; m1_read = 1'b1;
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) $display("FAIL contend_first got=%b exp=01", {m0_waitrequest, m1_waitrequest}); else pass_cnt++;
    tick(); m0_read = 1'b0; #1;   // SAMPLE
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL contend_m1_wait_sample got=%b exp=1", m1_waitrequest); else pass_cnt++;
    tick(); #1;                   // RESP (m0)
    total++; if ({m0_readdatavalid, m1_readdatavalid, m1_waitrequest} !== 3'b101) $display("FAIL contend_m0_resp got=%b exp=101", {m0_readdatavalid, m1_readdatavalid, m1_waitrequest}); else pass_cnt++;
    total++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL contend_m0_data got=%h exp=deadbeef", m0_readdata); else pass_cnt++;
    tick(); #1;                   // IDLE: m1 accepted
    total++; if ({m0_readdatavalid, m1_waitrequest} !== 2'b00) $display("FAIL contend_m1_accept got=%b exp=00", {m0_readdatavalid, m1_waitrequest}); else pass_cnt++;
    tick(); m1_read = 1'b0; #1;   // SAMPLE
    total++; if (s_address !== 1'b1) $display("FAIL contend_saddr got=%b exp=1", s_address); else pass_cnt++;
    tick(); #1;                   // RESP (m1)
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) $display("FAIL contend_m1_rdv got=%b exp=01", {m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
    total++; if (m1_readdata !== 32'h5B92B411) $display("FAIL contend_m1_data got=%h exp=5b92b411", m1_readdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   n_grant = 0;
    int   n_rdv   = 0;
    int   n_ovl   = 0;
    logic [3:0] seq = '0;
    do_reset();
    m0_address = 1'b0; m1_address = 1'b1;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (!m0_waitrequest) begin seq = {seq[2:0], 1'b0}; n_grant++; end
      if (!m1_waitrequest) begin seq = {seq[2:0], 1'b1}; n_grant++; end
      if (m0_readdatavalid) n_rdv++;
      if (m1_readdatavalid) n_rdv++;
      if (m0_readdatavalid && m1_readdatavalid) n_ovl++;
      tick();
    end
    m0_read = 1'b0; m1_read = 1'b0;
    total++; if (n_grant !== 4) $display("FAIL b2b_grants got=%0d exp=4", n_grant); else pass_cnt++;
    total++; if (seq !== 4'b0101) $display("FAIL b2b_order got=%b exp=0101", seq); else pass_cnt++;
    total++; if (n_rdv !== 4) $display("FAIL b2b_rdv got=%0d exp=4", n_rdv); else pass_cnt++;
    total++; if (n_ovl !== 0) $display("FAIL b2b_overlap got=%0d exp=0", n_ovl); else pass_cnt++;
  endtask

  task automatic test_drop();
    int m1_rdv_seen = 0;
    do_reset();
    m0_address = 1'b0; m0_read = 1'b1;
    tick(); m0_read = 1'b0;       // SAMPLE of m0
    m1_address = 1'b1; m1_read = 1'b1; #1;
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL drop_m1_wait got=%b exp=1", m1_waitrequest); else pass_cnt++;
    tick(); m1_read = 1'b0;       // RESP, m1 withdrew
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m1_readdatavalid) m1_rdv_seen++;
      tick();
    end
    total++; if (m1_rdv_seen !== 0) $display("FAIL drop_no_m1_txn got=%0d exp=0", m1_rdv_seen); else pass_cnt++;
    // last_grant still 0 -> m1 wins the next contention
    m0_read = 1'b1; m1_read = 1'b1; #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) $display("FAIL drop_last_grant got=%b exp=10", {m0_waitrequest, m1_waitrequest}); else pass_cnt++;
    m0_read = 1'b0; m1_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rdv_seen = 0;
    do_reset();
    m0_address = 1'b1; m0_read = 1'b1;
    tick(); m0_read = 1'b0;       // SAMPLE, s_address = 1
    #1 reset_n = 1'b0;
    #1;
    total++; if (s_address !== 1'b0) $display("FAIL rstmid_saddr got=%b exp=0", s_address); else pass_cnt++;
    total++; if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 4'b1100) $display("FAIL rstmid_ctrl got=%b exp=1100", {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
    total++; if (m0_readdata !== 32'h0) $display("FAIL rstmid_rdata got=%h exp=0", m0_readdata); else pass_cnt++;
    tick(); reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m0_readdatavalid || m1_readdatavalid) rdv_seen++;
      tick();
    end
    total++; if (rdv_seen !== 0) $display("FAIL rstmid_no_rdv got=%0d exp=0", rdv_seen); else pass_cnt++;
  endtask

  task automatic test_idcheck();
`ifdef SYSID_ARB_IDCHECK_EN
    logic exp_flag = 1'b1;
`else
    logic exp_flag = 1'b0;
`endif
    id_val = 32'h12345678;
    do_reset();
    m0_address = 1'b0; m0_read = 1'b1;
    tick(); m0_read = 1'b0;       // SAMPLE
    tick(); #1;                   // RESP
    total++; if (id_mismatch !== 1'b0) $display("FAIL idchk_before got=%b exp=0", id_mismatch); else pass_cnt++;
    tick(); tick(); tick(); #1;   // flag set at RESP edge, then held
    total++; if (id_mismatch !== exp_flag) $display("FAIL idchk_addr0 got=%b exp=%b", id_mismatch, exp_flag); else pass_cnt++;
    do_reset();
    m0_address = 1'b1; m0_read = 1'b1;
    tick(); m0_read = 1'b0;
    tick(); tick(); tick(); #1;
    total++; if (id_mismatch !== 1'b0) $display("FAIL idchk_addr1 got=%b exp=0", id_mismatch); else pass_cnt++;
    id_val = 32'hDEADBEEF;
  endtask

  initial begin
    id_val = 32'hDEADBEEF;
    reset_n = 1'b0;
    m0_address = 1'b0; m1_address = 1'b0;
    m0_read = 1'b0; m1_read = 1'b0;
    #2;
    test_reset();
    test_single_m0();
    test_contention();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_idcheck();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
